// File: rtl/ahb_timer_satellite_if.sv
// AHB-lite slot bundle between the multiplexor and a satellite slave.
interface ahb_bus_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport satellite (
        input  haddr, htrans, hwrite, hsize, hburst, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_timer_satellite.sv
// Prescaled 32-bit compare timer on an AHB-lite slot; zero-wait OKAY transfers, read data combinational in the data phase.
// Non-word writes take a two-cycle ERROR (hready low in the first cycle); tmi is registered one cycle behind its cause.
module ahb_timer_satellite #(
    parameter int PRESCALE_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    ahb_bus_if.satellite abif,
    output logic         tmi
);
    typedef enum logic [1:0] {IDLE, ERR1, ERR2} bus_state_t;

    bus_state_t            state;
    logic                  hready_q, hresp_q;
    logic                  dphase, dwrite;
    logic [2:0]            doff;
    logic [2:0]            ctrl, ctrl_next;
    logic [PRESCALE_W-1:0] prescale, pcnt;
    logic [31:0]           count, compare, rdata;
    logic                  match, match_next;
    logic                  accept, bad_write, wr_en;
    logic                  wr_ctrl, wr_pre, wr_count, wr_cmp, wr_stat;
    logic                  tick, cnt_hit, match_set;
    logic                  unused_bits;

    assign unused_bits = &{1'b0, abif.haddr[31:5], abif.haddr[1:0], abif.hburst};

    assign accept    = abif.htrans[1] & hready_q;
    assign bad_write = abif.hwrite & (abif.hsize != 3'b010);
    assign wr_en     = dphase & dwrite;
    assign wr_ctrl   = wr_en & (doff == 3'd0);
    assign wr_pre    = wr_en & (doff == 3'd1);
    assign wr_count  = wr_en & (doff == 3'd2);
    assign wr_cmp    = wr_en & (doff == 3'd3);
    assign wr_stat   = wr_en & (doff == 3'd4);

    assign tick      = ctrl[0] & (pcnt == prescale);
    assign cnt_hit   = (count == compare);
    // A bus write to COUNT on the same edge suppresses the tick's match.
    assign match_set = tick & cnt_hit & ~wr_count;

    always_comb begin
        ctrl_next  = wr_ctrl ? abif.hwdata[2:0] : ctrl;
        match_next = match;
        if (match_set)
            match_next = 1'b1;
        else if (wr_stat && abif.hwdata[0])
            match_next = 1'b0;
    end

    always_comb begin
        rdata = '0;
        if (dphase && !dwrite) begin
            case (doff)
                3'd0:    rdata[2:0]            = ctrl;
                3'd1:    rdata[PRESCALE_W-1:0] = prescale;
                3'd2:    rdata                 = count;
                3'd3:    rdata                 = compare;
                3'd4:    rdata[0]              = match;
                default: rdata                 = '0;
            endcase
        end
    end

    assign abif.hrdata = rdata;
    assign abif.hready = hready_q;
    assign abif.hresp  = hresp_q;

    // Bus FSM: the error decision is made at the address edge so ERR1 lands in the data phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            dphase   <= 1'b0;
            dwrite   <= 1'b0;
            doff     <= 3'd0;
        end else begin
            dphase <= 1'b0;
            case (state)
                ERR1: begin
                    state    <= ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                default: begin
                    if (accept && bad_write) begin
                        state    <= ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                        if (accept) begin
                            dphase <= 1'b1;
                            dwrite <= abif.hwrite;
                            doff   <= abif.haddr[4:2];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= 3'd0;
            prescale <= '0;
            pcnt     <= '0;
            count    <= 32'd0;
            compare  <= 32'hFFFF_FFFF;
            match    <= 1'b0;
            tmi      <= 1'b0;
        end else begin
            ctrl  <= ctrl_next;
            match <= match_next;
            tmi   <= match_next & ctrl_next[2];
            if (wr_pre)
                prescale <= abif.hwdata[PRESCALE_W-1:0];
            if (wr_cmp)
                compare <= abif.hwdata;
            if (wr_pre || !ctrl[0] || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PRESCALE_W'(1);
            if (wr_count)
                count <= abif.hwdata;
            else if (tick)
                count <= (cnt_hit && ctrl[1]) ? 32'd0 : count + 32'd1;
        end
    end
endmodule

// File: tb/tb_ahb_timer_satellite.sv
// Randomized and directed bench for ahb_timer_satellite against a register-array reference model.
module tb_ahb_timer_satellite;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tmi;
    int   checks = 0;
    int   failures = 0;

    ahb_bus_if bus();

    ahb_timer_satellite #(.PRESCALE_W(PW)) dut (
        .clk  (clk),
        .rst  (rst),
        .abif (bus),
        .tmi  (tmi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as an array indexed by word offset (5..7 stay zero).
    logic [31:0]   m_regs [0:7];
    logic [PW-1:0] m_pcnt;
    logic          m_tmi;
    int            m_err = 0;   // error cycles still owed: 2 = first error cycle, 1 = second
    logic          m_dv = 1'b0, m_dw = 1'b0;
    logic [2:0]    m_doff = 3'd0;

    function automatic logic [31:0] wmask(input logic [2:0] off);
        case (off)
            3'd0:    return 32'h7;
            3'd1:    return 32'(17'h1FFFF >> 1);
            3'd2,
            3'd3:    return 32'hFFFF_FFFF;
            3'd4:    return 32'h1;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] nr [0:7];
        logic        wr_now, tick, hit, eq;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= (i == 3) ? 32'hFFFF_FFFF : 32'h0;
            m_pcnt <= '0;
            m_tmi  <= 1'b0;
            m_err  <= 0;
            m_dv   <= 1'b0;
            m_dw   <= 1'b0;
            m_doff <= 3'd0;
        end else begin
            nr     = m_regs;
            wr_now = m_dv && m_dw;
            eq     = (m_regs[2] == m_regs[3]);
            tick   = m_regs[0][0] && (m_pcnt == m_regs[1][PW-1:0]);
            hit    = tick && eq && !(wr_now && m_doff == 3'd2);
            if (wr_now && (m_doff inside {3'd0, 3'd1, 3'd3}))
                nr[m_doff] = bus.hwdata & wmask(m_doff);
            if (wr_now && m_doff == 3'd2)
                nr[2] = bus.hwdata;
            else if (tick)
                nr[2] = (eq && m_regs[0][1]) ? 32'h0 : 32'((64'(m_regs[2]) + 64'd1) % 64'h1_0000_0000);
            if (hit)
                nr[4] = 32'h1;
            else if (wr_now && m_doff == 3'd4 && bus.hwdata[0])
                nr[4] = 32'h0;
            m_pcnt <= (!m_regs[0][0] || tick || (wr_now && m_doff == 3'd1)) ? '0 : m_pcnt + PW'(1);
            m_tmi  <= nr[4][0] & nr[0][2];
            m_regs <= nr;
            if (bus.htrans[1] && m_err != 2) begin
                if (bus.hwrite && bus.hsize != 3'b010) begin
                    m_err <= 2;
                    m_dv  <= 1'b0;
                end else begin
                    m_err  <= 0;
                    m_dv   <= 1'b1;
                    m_dw   <= bus.hwrite;
                    m_doff <= bus.haddr[4:2];
                end
            end else begin
                m_err <= (m_err == 2) ? 1 : 0;
                m_dv  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] exp_rd;
        exp_rd = (m_dv && !m_dw) ? m_regs[m_doff] : 32'h0;
        check("hready", 32'(bus.hready), 32'(m_err != 2));
        check("hresp",  32'(bus.hresp),  32'(m_err != 0));
        check("hrdata", bus.hrdata, exp_rd);
        check("tmi",    32'(tmi), 32'(m_tmi));
    end

    task automatic bus_idle();
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'b010;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        bus.htrans = 2'b10;
        bus.haddr  = {27'd0, off, 2'b00};
        bus.hwrite = 1'b1;
        bus.hsize  = 3'b010;
        @(posedge clk); #1;
        bus_idle();
        bus.hwdata = d;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d, output logic resp);
        bus.htrans = 2'b10;
        bus.haddr  = {27'd0, off, 2'b00};
        bus.hwrite = 1'b0;
        bus.hsize  = 3'b010;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        d    = bus.hrdata;
        resp = bus.hresp;
        @(posedge clk); #1;
    endtask

    task automatic rd2(input logic [2:0] off, output logic [31:0] d0, output logic [31:0] d1);
        bus.htrans = 2'b10;
        bus.haddr  = {27'd0, off, 2'b00};
        bus.hwrite = 1'b0;
        bus.hsize  = 3'b010;
        @(posedge clk); #1;
        bus.htrans = 2'b11;
        @(negedge clk);
        d0 = bus.hrdata;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        d1 = bus.hrdata;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] d, d1;
        logic        r;
        int          n;
        bus.haddr  = 32'h0;
        bus.hburst = 3'b000;
        bus.hwdata = 32'h0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hready", 32'(bus.hready), 32'h1);
        check("rst_hresp",  32'(bus.hresp),  32'h0);
        check("rst_hrdata", bus.hrdata, 32'h0);
        check("rst_tmi",    32'(tmi), 32'h0);
        rst = 1'b0;

        // Read-back of all offsets.
        wr(3'd3, 32'hA5A5_0003);
        wr(3'd1, 32'd2);
        wr(3'd0, 32'h7);
        rd(3'd0, d, r); check("rb_ctrl", d, 32'h7); check("rb_resp", 32'(r), 32'h0);
        rd(3'd1, d, r); check("rb_prescale", d, 32'h2);
        rd(3'd3, d, r); check("rb_compare", d, 32'hA5A5_0003);
        rd(3'd4, d, r); check("rb_status", d, 32'h0);
        rd(3'd5, d, r); check("rb_off14", d, 32'h0);
        rd(3'd7, d, r); check("rb_off1c", d, 32'h0);

        // Prescale and match with auto-reload.
        do_reset();
        wr(3'd1, 32'd2);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'h7);
        n = 0;
        while (!tmi && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("pm_tmi_cycles", 32'(n), 32'd12);
        rd(3'd2, d, r); check("pm_count_reload", d, 32'h0);
        rd(3'd4, d, r); check("pm_match", d, 32'h1);
        wr(3'd4, 32'h1);
        check("pm_tmi_clear", 32'(tmi), 32'h0);
        rd(3'd4, d, r); check("pm_match_clear", d, 32'h0);

        // Free-running wrap past 0xFFFFFFFF without auto-reload.
        do_reset();
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd3, 32'd5);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h1);
        rd2(3'd2, d, d1);
        check("wrap_first", d, 32'h0);
        check("wrap_second", d1, 32'h1);
        rd(3'd4, d, r); check("wrap_match", d, 32'h0);

        // Byte write error; an address presented in ERR1 is dropped.
        do_reset();
        wr(3'd3, 32'h1234_5678);
        bus.htrans = 2'b10;
        bus.haddr  = 32'h0000_000C;
        bus.hwrite = 1'b1;
        bus.hsize  = 3'b000;
        @(posedge clk); #1;
        bus.hsize  = 3'b010;
        bus.hwdata = 32'hDEAD_BEEF;
        check("err1_hready", 32'(bus.hready), 32'h0);
        check("err1_hresp",  32'(bus.hresp),  32'h1);
        @(posedge clk); #1;
        bus.hwdata = 32'hCAFE_0000;
        check("err2_hready", 32'(bus.hready), 32'h1);
        check("err2_hresp",  32'(bus.hresp),  32'h1);
        rd(3'd3, d, r);
        check("err_compare", d, 32'h1234_5678);
        check("err_next_okay", 32'(r), 32'h0);

        // Collisions: COUNT write vs tick, W1C vs match set.
        do_reset();
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h1);
        wr(3'd2, 32'h10);
        rd(3'd2, d, r); check("col_count", d, 32'h11);
        wr(3'd3, 32'h21);
        wr(3'd2, 32'h20);
        wr(3'd4, 32'h1);
        rd(3'd4, d, r); check("col_match", d, 32'h1);

        // Reset asserted during ERR1.
        do_reset();
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h7);
        bus.htrans = 2'b10;
        bus.haddr  = 32'h0000_0008;
        bus.hwrite = 1'b1;
        bus.hsize  = 3'b001;
        @(posedge clk); #1;
        bus_idle();
        check("mr_tmi_before", 32'(tmi), 32'h1);
        check("mr_in_err1", 32'(bus.hready), 32'h0);
        rst = 1'b1;
        #1;
        check("mr_hready", 32'(bus.hready), 32'h1);
        check("mr_hresp",  32'(bus.hresp),  32'h0);
        check("mr_hrdata", bus.hrdata, 32'h0);
        check("mr_tmi",    32'(tmi), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd(3'd0, d, r); check("mr_ctrl", d, 32'h0); check("mr_resp", 32'(r), 32'h0);
        rd(3'd3, d, r); check("mr_compare", d, 32'hFFFF_FFFF);

        // Random traffic with a mid-run reset pulse.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.htrans = 2'($urandom_range(0, 3));
            bus.haddr  = $urandom;
            bus.hwrite = 1'($urandom_range(0, 1));
            bus.hsize  = ($urandom_range(0, 7) < 6) ? 3'b010 : 3'($urandom_range(0, 7));
            bus.hburst = 3'($urandom_range(0, 7));
            bus.hwdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            if (i == 1500) rst = 1'b1;
            if (i == 1502) rst = 1'b0;
            @(posedge clk); #1;
        end
        bus_idle();
        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
